// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM over a shared memory port.
// Define MULTICYCLE_CTRL_TRAP_EN to halt in TRAP on illegal instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        alu_src_imm,
  output logic [1:0]  imm_sel,
  output logic [3:0]  alu_ctrl,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLT  = 4'd5;
  localparam logic [3:0] A_SLL  = 4'd6;
  localparam logic [3:0] A_SRL  = 4'd7;
  localparam logic [3:0] A_SRA  = 4'd8;
  localparam logic [3:0] A_SLTU = 4'd9;
  localparam logic [3:0] A_PASB = 4'd10;

  state_t      cur;
  state_t      nxt;
  logic [31:0] cnt;
  logic        retire;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic        unused_rs;

  assign opc       = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign rd        = instr[11:7];
  assign unused_rs = ^instr[24:15];

  logic is_op, is_opi, is_ld, is_st, is_lui;
  logic op_ok, legal;

  assign is_op  = (opc == 7'b0110011);
  assign is_opi = (opc == 7'b0010011);
  assign is_ld  = (opc == 7'b0000011);
  assign is_st  = (opc == 7'b0100011);
  assign is_lui = (opc == 7'b0110111);

  assign op_ok = (f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) &&
                  ((f3 == 3'b000) || (f3 == 3'b101)));

  assign legal = (is_op && op_ok) || is_opi ||
                 is_ld || is_st || is_lui;

  logic [3:0] alu_base;
  logic [3:0] d_alu;
  logic       d_src;
  logic [1:0] d_isel;

  always_comb begin
    alu_base = A_ADD;
    unique case (f3)
      3'b000: alu_base = A_ADD;
      3'b001: alu_base = A_SLL;
      3'b010: alu_base = A_SLT;
      3'b011: alu_base = A_SLTU;
      3'b100: alu_base = A_XOR;
      3'b101: alu_base = A_SRL;
      3'b110: alu_base = A_OR;
      3'b111: alu_base = A_AND;
    endcase
  end

  // instr[30] is only an opcode modifier for SUB/SRA/SRAI
  always_comb begin
    d_alu  = A_ADD;
    d_src  = 1'b0;
    d_isel = 2'd0;
    unique case (1'b1)
      is_op: begin
        if (instr[30] && f3 == 3'b000)
          d_alu = A_SUB;
        else if (instr[30] && f3 == 3'b101)
          d_alu = A_SRA;
        else
          d_alu = alu_base;
      end
      is_opi: begin
        d_src = 1'b1;
        if (instr[30] && f3 == 3'b101)
          d_alu = A_SRA;
        else
          d_alu = alu_base;
      end
      is_ld: d_src = 1'b1;
      is_st: begin
        d_src  = 1'b1;
        d_isel = 2'd1;
      end
      is_lui: begin
        d_src  = 1'b1;
        d_isel = 2'd2;
        d_alu  = A_PASB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire)
        cnt <= cnt + 32'd1;
    end
  end

  logic       c_req, c_we, c_irwe, c_pcwe;
  logic       c_rwe, c_trap, dp_en;

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    c_req  = 1'b0;
    c_we   = 1'b0;
    c_irwe = 1'b0;
    c_pcwe = 1'b0;
    c_rwe  = 1'b0;
    c_trap = 1'b0;
    dp_en  = 1'b0;
    unique case (cur)
      S_FETCH: begin
        c_req = 1'b1;
        if (mem_ready) begin
          c_irwe = 1'b1;
          c_pcwe = 1'b1;
          nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal)
          nxt = S_EXEC;
        else
`ifdef MULTICYCLE_CTRL_TRAP_EN
          nxt = S_TRAP;
`else
          nxt = S_FETCH;
`endif
      end
      S_EXEC: begin
        dp_en = 1'b1;
        nxt   = (is_ld || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dp_en = 1'b1;
        c_req = 1'b1;
        c_we  = is_st;
        if (mem_ready) begin
          retire = is_st;
          nxt    = is_st ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        dp_en  = 1'b1;
        c_rwe  = (rd != 5'd0);
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        c_trap = 1'b1;
        nxt    = S_TRAP;
`else
        nxt    = S_FETCH;
`endif
      end
      default: nxt = S_FETCH;
    endcase
  end

  // reset masks every output combinationally, so an access drops at once
  assign mem_req     = !reset && c_req;
  assign mem_we      = !reset && c_we;
  assign ir_we       = !reset && c_irwe;
  assign pc_we       = !reset && c_pcwe;
  assign reg_we      = !reset && c_rwe;
  assign trap        = !reset && c_trap;
  assign alu_src_imm = !reset && dp_en && d_src;
  assign imm_sel     = (!reset && dp_en) ? d_isel : 2'd0;
  assign alu_ctrl    = (!reset && dp_en) ? d_alu : 4'd0;
  assign state       = reset ? 3'd0 : cur;
  assign instr_count = reset ? 32'd0 : cnt;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I integer core. It sequences instruction fetch, decode, execute, memory access and register writeback over a shared single-port memory. It drives the register file, the ALU, the immediate-extension select and the PC/IR write strobes. It sits between the instruction register and the datapath, and decodes `instr` once per instruction.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register contents, valid from DECODE onward
- mem_ready  in  1  memory has completed the access requested this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  access is a write; valid only with mem_req
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC <= PC+4
- reg_we  out  1  register-file write enable
- alu_src_imm  out  1  ALU B operand = extended immediate (0 = rs2)
- imm_sel  out  2  immediate format: 0 I-type, 1 S-type, 2 U-type
- alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 SLTU, 10 PASSB
- trap  out  1  illegal instruction halt
- state  out  3  FSM state, for debug
- instr_count  out  32  count of retired instructions

## Operation
- States:
  - FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Supported opcodes:
  - OP (0110011), OP-IMM (0010011), LOAD (0000011), STORE (0100011), LUI (0110111).
- FETCH:
  - mem_req = 1, mem_we = 0.
  - Stay in FETCH until mem_ready.
  - On mem_ready, pulse ir_we = 1 and pc_we = 1 for that cycle, then go to DECODE.
- DECODE:
  - Legal instruction → EXEC.
  - Illegal instruction → see Configuration.
- EXEC:
  - OP, OP-IMM and LUI → WB.
  - LOAD and STORE → MEM.
- MEM:
  - mem_req = 1; mem_we = 1 for STORE only.
  - Stay in MEM until mem_ready.
  - On mem_ready: LOAD → WB; STORE retires → FETCH.
- WB:
  - reg_we = 1 unless rd (instr[11:7]) == 0.
  - Instruction retires → FETCH.
- Datapath controls, valid in EXEC, MEM and WB (0 in other states):
  - OP: alu_src_imm = 0. funct3 selects the operation; funct7[5] = 1 selects SUB for funct3 = 000 and SRA for funct3 = 101.
  - OP-IMM: alu_src_imm = 1, imm_sel = 0. funct7[5] is honoured only for funct3 = 101 (SRAI).
  - LOAD: alu_src_imm = 1, imm_sel = 0, ADD.
  - STORE: alu_src_imm = 1, imm_sel = 1, ADD.
  - LUI: alu_src_imm = 1, imm_sel = 2, PASSB.
- Illegal instruction:
  - unsupported opcode, or
  - OP with funct7 ∉ {0000000, 0100000}, or
  - OP with funct7 = 0100000 and funct3 ∉ {000, 101}.
- instr_count:
  - +1 on each retirement (WB cycle, or STORE MEM cycle with mem_ready).
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset behaviour:
  - While reset is high, all outputs are forced to 0 and mem_ready is ignored.
  - On the edge where reset is sampled high: state ← FETCH, instr_count ← 0.
  - First mem_req is in the cycle after reset deasserts.
- Reset mid-operation abandons any access; mem_req drops in the same cycle reset rises.
- Outputs are combinational from state and instr. No output depends on mem_ready except ir_we and pc_we.
- Latency with zero-wait memory (mem_ready high in the request cycle):
  - OP / OP-IMM / LUI: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1 cycle.
- mem_req never deasserts before mem_ready, except on reset.
- TRAP is sticky until reset: trap = 1, all other controls 0.

## Configuration
- `MULTICYCLE_CTRL_TRAP_EN` defined:
  - Illegal instruction in DECODE → TRAP; the next cycle trap = 1.
  - The instruction does not retire.
- `MULTICYCLE_CTRL_TRAP_EN` undefined:
  - Illegal instruction in DECODE → FETCH (no-op); instr_count unchanged.
  - trap is tied to 0 and the TRAP state is unreachable.

## Test plan
- addi x1, x0, -5 (0xFFB00093), mem_ready held 1 → states 0, 1, 2, 4. In EXEC: alu_src_imm = 1, imm_sel = 0, alu_ctrl = 0. reg_we = 1 in cycle 4; instr_count = 1.
- sub x3, x1, x2 (0x402081B3) → alu_ctrl = 1, alu_src_imm = 0, reg_we in WB. sra (0x4020D1B3) → alu_ctrl = 8.
- lw x5, 8(x0) (0x00802283) with mem_ready low for 2 cycles in MEM → mem_req held 3 cycles in MEM, then WB with reg_we = 1. Total 7 cycles.
- sw x5, 4(x0) (0x00502223) → MEM with mem_req = 1, mem_we = 1, imm_sel = 1. Retires at mem_ready with no WB state.
- addi x0, x0, 1 (0x00100013) → reg_we stays 0 in WB; instr_count still increments.
- instr = 0x00000000:
  - With MULTICYCLE_CTRL_TRAP_EN: state = 5, trap = 1, mem_req stays 0 for 10 cycles; reset returns to FETCH with instr_count = 0.
  - Without it: back to FETCH after DECODE, instr_count unchanged.
- Reset asserted during a MEM wait → mem_req = 0 that cycle; FETCH and mem_req = 1 one cycle after reset deasserts.
